// File: rtl/router_dispatch_n.sv
// Descriptor dispatch for the router read side: decodes destination to an output
// port, runs a per-port IDLE/BUSY/RET handshake and recycles slot indices through a free FIFO.
module router_dispatch_n #(
   parameter int                         NPORTS  = 3,
   parameter int                         UWIDTH  = 8,
   parameter int                         PTR_SZ  = 2,
   parameter logic [NPORTS*UWIDTH-1:0]   PORT_HI = {8'd255, 8'd195, 8'd127},
   localparam int                        AW      = $clog2(NPORTS + 1)
) (
   input  logic                       clk2,
   input  logic                       rst,
   input  logic                       desc_valid,
   output logic                       desc_ready,
   input  logic [PTR_SZ-1:0]          desc_idx,
   input  logic [UWIDTH-1:0]          desc_dest,
   output logic [NPORTS-1:0]          port_en,
   output logic [NPORTS*PTR_SZ-1:0]   port_raddr,
   input  logic [NPORTS-1:0]          port_done,
   output logic                       free_valid,
   input  logic                       free_ready,
   output logic [PTR_SZ-1:0]          free_idx,
   output logic [AW-1:0]              active_ports,
   output logic [7:0]                 drop_cnt
);

   // state  | meaning
   // S_IDLE | port free, may take the next descriptor decoded to it
   // S_BUSY | port_en high, port reading slot raddr
   // S_RET  | read finished, slot index waiting for its turn into the free FIFO

   localparam int DEPTH = 1 << PTR_SZ;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RET  = 2'd2
   } port_st_e;

   port_st_e            st_q    [NPORTS];
   port_st_e            st_d    [NPORTS];
   logic [PTR_SZ-1:0]   raddr_q [NPORTS];
   logic [PTR_SZ-1:0]   raddr_d [NPORTS];
   logic [PTR_SZ-1:0]   mem_q   [DEPTH];
   logic [PTR_SZ-1:0]   mem_d   [DEPTH];
   logic [PTR_SZ:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_SZ:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]       active_q, active_d;
   logic [7:0]          drop_q, drop_d;

   logic [NPORTS-1:0]   tgt_oh;
   logic                in_range;
   logic [NPORTS-1:0]   ret_oh;
   logic                ret_any;
   logic [PTR_SZ-1:0]   ret_idx;
   logic [NPORTS-1:0]   idle_vec;
   logic                fifo_full;
   logic                fifo_empty;
   logic                accept;
   logic                drop_push;
   logic                ret_push;
   logic                push;
   logic [PTR_SZ-1:0]   push_data;
   logic                pop;

   // Lowest port whose upper bound covers the destination wins.
   always_comb begin
      tgt_oh   = '0;
      in_range = 1'b0;
      for (int k = 0; k < NPORTS; k++) begin
         if (!in_range && (desc_dest <= PORT_HI[k*UWIDTH +: UWIDTH])) begin
            tgt_oh[k] = 1'b1;
            in_range  = 1'b1;
         end
      end
   end

   always_comb begin
      ret_oh   = '0;
      ret_any  = 1'b0;
      ret_idx  = '0;
      idle_vec = '0;
      for (int k = 0; k < NPORTS; k++) begin
         idle_vec[k] = (st_q[k] == S_IDLE);
         if (!ret_any && (st_q[k] == S_RET)) begin
            ret_oh[k] = 1'b1;
            ret_any   = 1'b1;
            ret_idx   = raddr_q[k];
         end
      end
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_SZ] != rd_ptr_q[PTR_SZ]) &&
                       (wr_ptr_q[PTR_SZ-1:0] == rd_ptr_q[PTR_SZ-1:0]);

   // Drops only accepted while no port is returning, so the two push sources never collide.
   assign desc_ready = in_range ? |(tgt_oh & idle_vec) : (!ret_any && !fifo_full);
   assign accept     = desc_valid && desc_ready;
   assign drop_push  = accept && !in_range;
   assign ret_push   = ret_any && !fifo_full;
   assign push       = drop_push || ret_push;
   assign push_data  = drop_push ? desc_idx : ret_idx;
   assign pop        = !fifo_empty && free_ready;

   always_comb begin
      st_d     = st_q;
      raddr_d  = raddr_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      drop_d   = drop_q;
      active_d = '0;

      for (int k = 0; k < NPORTS; k++) begin
         case (st_q[k])
            S_IDLE: begin
               if (accept && tgt_oh[k]) begin
                  st_d[k]    = S_BUSY;
                  raddr_d[k] = desc_idx;
               end
            end
            S_BUSY: begin
               if (port_done[k]) st_d[k] = S_RET;
            end
            S_RET: begin
               if (ret_push && ret_oh[k]) st_d[k] = S_IDLE;
            end
            default: st_d[k] = S_IDLE;
         endcase
         active_d = active_d + AW'(st_d[k] != S_IDLE);
      end

      if (push) begin
         mem_d[wr_ptr_q[PTR_SZ-1:0]] = push_data;
         wr_ptr_d = wr_ptr_q + (PTR_SZ+1)'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + (PTR_SZ+1)'(1);

      if (drop_push && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NPORTS; k++) begin
            st_q[k]    <= S_IDLE;
            raddr_q[k] <= '0;
         end
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         active_q <= '0;
         drop_q   <= '0;
      end else begin
         st_q     <= st_d;
         raddr_q  <= raddr_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         active_q <= active_d;
         drop_q   <= drop_d;
      end
   end

   always_comb begin
      port_en    = '0;
      port_raddr = '0;
      for (int k = 0; k < NPORTS; k++) begin
         port_en[k]                       = (st_q[k] == S_BUSY);
         port_raddr[k*PTR_SZ +: PTR_SZ]   = raddr_q[k];
      end
   end

   assign free_valid   = !fifo_empty;
   assign free_idx     = mem_q[rd_ptr_q[PTR_SZ-1:0]];
   assign active_ports = active_q;
   assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_router_dispatch_n.sv
// Scoreboard bench for router_dispatch_n: expected dispatches and recycled indices are
// queued as stimulus is driven and popped when the DUT shows them.
module tb_router_dispatch_n;

   logic clk2 = 1'b0;
   always #5 clk2 = ~clk2;

   logic       rst;

   logic       desc_valid, desc_ready;
   logic [1:0] desc_idx;
   logic [7:0] desc_dest;
   logic [2:0] port_en;
   logic [5:0] port_raddr;
   logic [2:0] port_done;
   logic       free_valid, free_ready;
   logic [1:0] free_idx;
   logic [1:0] active_ports;
   logic [7:0] drop_cnt;

   logic       d2_desc_valid, d2_desc_ready;
   logic [1:0] d2_desc_idx;
   logic [7:0] d2_desc_dest;
   logic [2:0] d2_port_en;
   logic [5:0] d2_port_raddr;
   logic [2:0] d2_port_done;
   logic       d2_free_valid, d2_free_ready;
   logic [1:0] d2_free_idx;
   logic [1:0] d2_active_ports;
   logic [7:0] d2_drop_cnt;

   router_dispatch_n u_dut (
      .clk2(clk2), .rst(rst),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_idx(desc_idx), .desc_dest(desc_dest),
      .port_en(port_en), .port_raddr(port_raddr), .port_done(port_done),
      .free_valid(free_valid), .free_ready(free_ready), .free_idx(free_idx),
      .active_ports(active_ports), .drop_cnt(drop_cnt)
   );

   router_dispatch_n #(.PORT_HI({8'd200, 8'd150, 8'd100})) u_dut_oor (
      .clk2(clk2), .rst(rst),
      .desc_valid(d2_desc_valid), .desc_ready(d2_desc_ready),
      .desc_idx(d2_desc_idx), .desc_dest(d2_desc_dest),
      .port_en(d2_port_en), .port_raddr(d2_port_raddr), .port_done(d2_port_done),
      .free_valid(d2_free_valid), .free_ready(d2_free_ready), .free_idx(d2_free_idx),
      .active_ports(d2_active_ports), .drop_cnt(d2_drop_cnt)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   typedef struct {
      int port;
      int idx;
   } disp_t;

   disp_t      disp_q[$];
   int         free_q[$];
   int         exp_raddr[3];
   logic       mon_en = 1'b0;
   logic [2:0] en_prev = 3'b000;
   disp_t      mon_e;

   always @(negedge clk2) begin
      if (mon_en) begin
         for (int k = 0; k < 3; k++) begin
            if (port_en[k] && !en_prev[k]) begin
               if (disp_q.size() == 0) begin
                  check_val("disp_unexpected", 1, 0);
               end else begin
                  mon_e = disp_q.pop_front();
                  check_val("disp_port", k, mon_e.port);
                  check_val("disp_raddr", port_raddr[k*2 +: 2], mon_e.idx);
               end
            end
         end
         if (free_valid && free_ready) begin
            if (free_q.size() == 0) check_val("free_unexpected", 1, 0);
            else                    check_val("free_idx", free_idx, free_q.pop_front());
         end
      end
      en_prev = port_en;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk2);
      #1;
   endtask

   task automatic send_desc(input int idx, input int dest, input int port);
      bit ok = 1'b0;
      desc_idx   = 2'(idx);
      desc_dest  = 8'(dest);
      desc_valid = 1'b1;
      for (int w = 0; w < 50 && !ok; w++) begin
         @(negedge clk2);
         if (desc_ready) begin
            ok = 1'b1;
            @(posedge clk2);
            disp_q.push_back('{port: port, idx: idx});
            exp_raddr[port] = idx;
            #1;
         end else begin
            @(posedge clk2);
            #1;
         end
      end
      desc_valid = 1'b0;
      if (!ok) check_val("send_timeout", 0, 1);
   endtask

   task automatic pulse_done(input logic [2:0] m);
      port_done = m;
      for (int k = 0; k < 3; k++) if (m[k]) free_q.push_back(exp_raddr[k]);
      @(posedge clk2);
      #1;
      port_done = 3'b000;
   endtask

   int dests[5] = '{127, 128, 195, 196, 255};
   int idxs [5] = '{0, 1, 2, 3, 0};
   int ports[5] = '{0, 1, 1, 2, 2};
   int acc;

   initial begin
      rst           = 1'b0;
      desc_valid    = 1'b0;
      desc_idx      = '0;
      desc_dest     = '0;
      port_done     = '0;
      free_ready    = 1'b1;
      d2_desc_valid = 1'b0;
      d2_desc_idx   = '0;
      d2_desc_dest  = '0;
      d2_port_done  = '0;
      d2_free_ready = 1'b1;

      #12;
      check_val("rst_port_en", port_en, 0);
      check_val("rst_raddr", port_raddr, 0);
      check_val("rst_free_valid", free_valid, 0);
      check_val("rst_free_idx", free_idx, 0);
      check_val("rst_active", active_ports, 0);
      check_val("rst_drop", drop_cnt, 0);
      @(negedge clk2);
      rst = 1'b1;
      wait_cycles(1);
      mon_en = 1'b1;

      // basic dispatch and return
      send_desc(1, 10, 0);
      check_val("basic_en", port_en, 3'b001);
      check_val("basic_raddr0", port_raddr[1:0], 1);
      check_val("basic_active", active_ports, 1);
      pulse_done(3'b001);
      check_val("basic_en_off", port_en, 0);
      check_val("basic_ret_active", active_ports, 1);
      check_val("basic_fv_early", free_valid, 0);
      wait_cycles(1);
      check_val("basic_fv", free_valid, 1);
      check_val("basic_fidx", free_idx, 1);
      check_val("basic_active_0", active_ports, 0);
      wait_cycles(2);

      // range decode boundaries
      for (int i = 0; i < 5; i++) begin
         send_desc(idxs[i], dests[i], ports[i]);
         wait_cycles(1);
         pulse_done(3'(1 << ports[i]));
         wait_cycles(3);
      end

      // head-of-line blocking
      send_desc(2, 5, 0);
      desc_idx   = 2'd3;
      desc_dest  = 8'd5;
      desc_valid = 1'b1;
      repeat (3) begin
         @(negedge clk2);
         check_val("hol_block", desc_ready, 0);
         @(posedge clk2);
         #1;
      end
      pulse_done(3'b001);
      @(negedge clk2);
      check_val("hol_ret", desc_ready, 0);
      @(posedge clk2);
      #1;
      @(negedge clk2);
      check_val("hol_release", desc_ready, 1);
      @(posedge clk2);
      disp_q.push_back('{port: 0, idx: 3});
      exp_raddr[0] = 3;
      #1;
      desc_valid = 1'b0;
      wait_cycles(1);
      pulse_done(3'b001);
      wait_cycles(3);

      // simultaneous done
      send_desc(2, 10, 0);
      send_desc(0, 150, 1);
      send_desc(3, 200, 2);
      check_val("sim_active3", active_ports, 3);
      pulse_done(3'b111);
      check_val("sim_active_ret", active_ports, 3);
      for (int c = 2; c >= 0; c--) begin
         wait_cycles(1);
         check_val("sim_active_step", active_ports, c);
      end
      wait_cycles(2);
      check_val("sb_free_drained", free_q.size(), 0);
      check_val("sb_disp_drained", disp_q.size(), 0);

      // out-of-range drops on the narrow-range instance
      d2_desc_idx   = 2'd2;
      d2_desc_dest  = 8'd230;
      d2_desc_valid = 1'b1;
      @(negedge clk2);
      check_val("oor_ready", d2_desc_ready, 1);
      @(posedge clk2);
      #1;
      d2_desc_valid = 1'b0;
      check_val("oor_no_en", d2_port_en, 0);
      check_val("oor_fv", d2_free_valid, 1);
      check_val("oor_fidx", d2_free_idx, 2);
      check_val("oor_drop1", d2_drop_cnt, 1);
      wait_cycles(1);
      d2_desc_valid = 1'b1;
      acc = 1;
      for (int w = 0; w < 400 && acc < 300; w++) begin
         @(negedge clk2);
         if (d2_desc_ready) acc++;
         @(posedge clk2);
         #1;
      end
      d2_desc_valid = 1'b0;
      check_val("oor_accepts", acc, 300);
      check_val("oor_drop_sat", d2_drop_cnt, 255);
      check_val("oor_no_en2", d2_port_en, 0);
      d2_desc_dest  = 8'd101;
      d2_desc_idx   = 2'd1;
      d2_desc_valid = 1'b1;
      wait_cycles(1);
      d2_desc_dest = 8'd100;
      d2_desc_idx  = 2'd3;
      wait_cycles(1);
      d2_desc_valid = 1'b0;
      check_val("oor_inrange_en", d2_port_en, 3'b011);
      check_val("oor_inrange_raddr", d2_port_raddr[3:0], 4'b0111);

      // reset while busy with a queued free entry
      free_ready = 1'b0;
      send_desc(1, 250, 2);
      wait_cycles(1);
      pulse_done(3'b100);
      wait_cycles(2);
      check_val("mid_fv", free_valid, 1);
      send_desc(0, 10, 0);
      send_desc(2, 130, 1);
      check_val("mid_active", active_ports, 2);
      check_val("mid_en", port_en, 3'b011);
      @(negedge clk2);
      #2;
      mon_en = 1'b0;
      rst    = 1'b0;
      #1;
      check_val("arst_port_en", port_en, 0);
      check_val("arst_raddr", port_raddr, 0);
      check_val("arst_fv", free_valid, 0);
      check_val("arst_fidx", free_idx, 0);
      check_val("arst_active", active_ports, 0);
      check_val("arst_drop", drop_cnt, 0);
      check_val("arst_d2_drop", d2_drop_cnt, 0);
      free_q.delete();
      disp_q.delete();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
